// File: rtl/sram_init_arbiter.sv
// sram_init_arbiter: owns the external SRAM bus for core, HPS loader and clear engine.
// Optional clear read-back verify is enabled by defining SRAM_CLR_VERIFY_EN.
module sram_init_arbiter #(
   parameter int            AW      = 21,
   parameter int            DW      = 8,
   parameter logic [DW-1:0] CLR_VAL = '0,
   parameter int            WR_CYC  = 2
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          mem_size,
   input  logic          clr_req,
   output logic          clr_busy,
   output logic          clr_err,
   output logic          core_hold,
   input  logic          ldr_active,
   input  logic          ldr_wr,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_data,
   output logic          ldr_wait,
   input  logic [AW-1:0] core_a,
   input  logic [DW-1:0] core_do,
   output logic [DW-1:0] core_di,
   input  logic          core_nce,
   input  logic          core_noe,
   input  logic          core_nwe,
   output logic [AW-1:0] SRAM_A,
   output logic [DW-1:0] SRAM_DO,
   input  logic [DW-1:0] SRAM_DI,
   output logic          SRAM_nCE,
   output logic          SRAM_nOE,
   output logic          SRAM_nWE
);

   localparam int CW = (WR_CYC > 1) ? $clog2(WR_CYC) : 1;
   localparam logic [CW-1:0] WC_LAST = CW'(WR_CYC - 1);
   localparam logic [CW-1:0] WC_ONE  = CW'(1);
   localparam logic [AW:0]   ADDR_ONE = {{AW{1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      IDLE,
      C_SET,
      C_STB,
      C_REL,
`ifdef SRAM_CLR_VERIFY_EN
      V_RD0,
      V_RD1,
`endif
      L_SET,
      L_STB,
      L_REL
   } state_t;

   state_t        state;
   logic [AW:0]   clr_addr;
   logic [AW:0]   end_addr;
   logic [AW:0]   end_sel;
   logic [AW:0]   clr_next;
   logic          clr_last;
   logic [CW-1:0] wcnt;
   logic [AW-1:0] ldr_a_q;
   logic [DW-1:0] ldr_d_q;
   logic          ldr_take;
   logic [AW-1:0] eng_a;
   logic [DW-1:0] eng_do;
   logic          eng_nce;
   logic          eng_noe;
   logic          eng_nwe;
   logic          bypass;

   // Terminal address is picked from mem_size when a clear starts
   assign end_sel  = mem_size ? {2'b00, {(AW-1){1'b1}}}
                              : {1'b0, {AW{1'b1}}};
   assign clr_next = clr_addr + ADDR_ONE;
   assign clr_last = (clr_addr == end_addr);
   assign ldr_take = ldr_wr && ldr_active && !ldr_wait;

   assign core_hold = clr_busy || ldr_active || ldr_wait;
   assign core_di   = SRAM_DI;

`ifdef SRAM_CLR_VERIFY_EN
   logic err_q;
   assign clr_err = err_q;
`else
   assign clr_err = 1'b0;
`endif

   // Engine FSM: clear, optional verify and loader writes; outputs registered
   always_ff @(posedge clk_sys) begin
      if (ldr_take) begin
         ldr_a_q <= ldr_addr;
         ldr_d_q <= ldr_data;
      end
      if (reset || clr_req) begin
         state    <= C_SET;
         clr_addr <= '0;
         end_addr <= end_sel;
         clr_busy <= 1'b1;
         ldr_wait <= !reset && (ldr_wait || ldr_take);
         wcnt     <= '0;
         eng_a    <= '0;
         eng_do   <= reset ? '0 : CLR_VAL;
         eng_nce  <= reset;
         eng_noe  <= 1'b1;
         eng_nwe  <= 1'b1;
`ifdef SRAM_CLR_VERIFY_EN
         err_q    <= 1'b0;
`endif
      end else begin
         if (ldr_take) ldr_wait <= 1'b1;
         unique case (state)
            IDLE: begin
               if (ldr_wait || ldr_take) begin
                  state   <= L_SET;
                  eng_a   <= ldr_wait ? ldr_a_q : ldr_addr;
                  eng_do  <= ldr_wait ? ldr_d_q : ldr_data;
                  eng_nce <= 1'b0;
                  eng_noe <= 1'b1;
                  eng_nwe <= 1'b1;
               end
            end
            C_SET: begin
               state   <= C_STB;
               wcnt    <= '0;
               eng_do  <= CLR_VAL;
               eng_nce <= 1'b0;
               eng_nwe <= 1'b0;
            end
            C_STB: begin
               if (wcnt == WC_LAST) begin
                  state   <= C_REL;
                  eng_nwe <= 1'b1;
               end else begin
                  wcnt <= wcnt + WC_ONE;
               end
            end
            C_REL: begin
               if (clr_last) begin
`ifdef SRAM_CLR_VERIFY_EN
                  state    <= V_RD0;
                  clr_addr <= '0;
                  eng_a    <= '0;
                  eng_noe  <= 1'b0;
`else
                  state    <= IDLE;
                  clr_busy <= 1'b0;
                  eng_nce  <= 1'b1;
`endif
               end else begin
                  state    <= C_SET;
                  clr_addr <= clr_next;
                  eng_a    <= clr_next[AW-1:0];
               end
            end
`ifdef SRAM_CLR_VERIFY_EN
            V_RD0: begin
               state <= V_RD1;
            end
            V_RD1: begin
               if (SRAM_DI != CLR_VAL) err_q <= 1'b1;
               if (clr_last) begin
                  state    <= IDLE;
                  clr_busy <= 1'b0;
                  eng_nce  <= 1'b1;
                  eng_noe  <= 1'b1;
               end else begin
                  state    <= V_RD0;
                  clr_addr <= clr_next;
                  eng_a    <= clr_next[AW-1:0];
               end
            end
`endif
            L_SET: begin
               state   <= L_STB;
               wcnt    <= '0;
               eng_nwe <= 1'b0;
            end
            L_STB: begin
               if (wcnt == WC_LAST) begin
                  state   <= L_REL;
                  eng_nwe <= 1'b1;
               end else begin
                  wcnt <= wcnt + WC_ONE;
               end
            end
            L_REL: begin
               state    <= IDLE;
               ldr_wait <= 1'b0;
               eng_nce  <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Core owns the bus only when idle with no loader session or pending write
   always_comb begin
      bypass = (state == IDLE) && !ldr_active && !ldr_wait;
      if (bypass) begin
         SRAM_A   = core_a;
         SRAM_DO  = core_do;
         SRAM_nCE = core_nce;
         SRAM_nOE = core_noe;
         SRAM_nWE = core_nwe;
      end else begin
         SRAM_A   = eng_a;
         SRAM_DO  = eng_do;
         SRAM_nCE = eng_nce;
         SRAM_nOE = eng_noe;
         SRAM_nWE = eng_nwe;
      end
   end

endmodule

// File: tb/tb_sram_init_arbiter.sv
// tb_sram_init_arbiter: directed bench for sram_init_arbiter (AW=8, WR_CYC=2).
// Expectations follow SRAM_CLR_VERIFY_EN when it is defined.
module tb_sram_init_arbiter;

   localparam int AW = 8;
   localparam int DW = 8;
`ifdef SRAM_CLR_VERIFY_EN
   localparam int VER = 1;
`else
   localparam int VER = 0;
`endif

   logic          clk_sys = 1'b0;
   logic          reset;
   logic          mem_size;
   logic          clr_req;
   logic          clr_busy;
   logic          clr_err;
   logic          core_hold;
   logic          ldr_active;
   logic          ldr_wr;
   logic [AW-1:0] ldr_addr;
   logic [DW-1:0] ldr_data;
   logic          ldr_wait;
   logic [AW-1:0] core_a;
   logic [DW-1:0] core_do;
   logic [DW-1:0] core_di;
   logic          core_nce;
   logic          core_noe;
   logic          core_nwe;
   logic [AW-1:0] SRAM_A;
   logic [DW-1:0] SRAM_DO;
   logic [DW-1:0] SRAM_DI;
   logic          SRAM_nCE;
   logic          SRAM_nOE;
   logic          SRAM_nWE;

   int checks = 0;
   int failures = 0;

   always #5 clk_sys = ~clk_sys;

   sram_init_arbiter #(
      .AW(AW),
      .DW(DW),
      .CLR_VAL(8'h00),
      .WR_CYC(2)
   ) dut (
      .clk_sys(clk_sys),
      .reset(reset),
      .mem_size(mem_size),
      .clr_req(clr_req),
      .clr_busy(clr_busy),
      .clr_err(clr_err),
      .core_hold(core_hold),
      .ldr_active(ldr_active),
      .ldr_wr(ldr_wr),
      .ldr_addr(ldr_addr),
      .ldr_data(ldr_data),
      .ldr_wait(ldr_wait),
      .core_a(core_a),
      .core_do(core_do),
      .core_di(core_di),
      .core_nce(core_nce),
      .core_noe(core_noe),
      .core_nwe(core_nwe),
      .SRAM_A(SRAM_A),
      .SRAM_DO(SRAM_DO),
      .SRAM_DI(SRAM_DI),
      .SRAM_nCE(SRAM_nCE),
      .SRAM_nOE(SRAM_nOE),
      .SRAM_nWE(SRAM_nWE)
   );

   // SRAM model with read override and one stuck location
   logic [7:0] mem [256];
   logic       di_ovr_en = 1'b0;
   logic [7:0] di_ovr = 8'h00;
   logic       bad_en = 1'b0;

   always_comb begin
      if (di_ovr_en) SRAM_DI = di_ovr;
      else if (bad_en && SRAM_A == 8'h33) SRAM_DI = 8'hFF;
      else SRAM_DI = mem[SRAM_A];
   end

   always @(posedge clk_sys)
      if (!SRAM_nCE && !SRAM_nWE) mem[SRAM_A] <= SRAM_DO;

   // Write-pulse recorder: address, data, low length
   int   pa[$];
   int   pd[$];
   int   pl[$];
   logic in_p = 1'b0;
   int   plen = 0;

   always @(negedge clk_sys) begin
      if (!SRAM_nWE && !SRAM_nCE) begin
         if (!in_p) begin
            pa.push_back(int'(SRAM_A));
            pd.push_back(int'(SRAM_DO));
            plen = 0;
         end
         in_p = 1'b1;
         plen++;
      end else if (in_p) begin
         pl.push_back(plen);
         in_p = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clrq();
      #2;
      pa.delete();
      pd.delete();
      pl.delete();
   endtask

   task automatic start_clear(input logic ms);
      @(negedge clk_sys);
      mem_size = ms;
      clr_req = 1'b1;
      @(negedge clk_sys);
      clr_req = 1'b0;
      clrq();
   endtask

   task automatic wait_clear(output int cnt);
      bit done;
      done = 1'b0;
      cnt = 0;
      for (int i = 0; i < 4000 && !done; i++) begin
         if (!clr_busy) done = 1'b1;
         else begin
            cnt++;
            @(negedge clk_sys);
         end
      end
      if (!done) chk("clear_timeout", 32'd0, 32'd1);
   endtask

   function automatic int seq_errs(input int n);
      int e;
      e = 0;
      if (pa.size() != n || pl.size() != n) e++;
      for (int i = 0; i < pa.size(); i++) begin
         if (pa[i] != i || pd[i] != 0) e++;
         if (i < pl.size() && pl[i] != 2) e++;
      end
      return e;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cnt;
      int  wc;
      int  drop;
      bit  found;
      for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
      reset = 1'b1;
      mem_size = 1'b0;
      clr_req = 1'b0;
      ldr_active = 1'b0;
      ldr_wr = 1'b0;
      ldr_addr = '0;
      ldr_data = '0;
      core_a = '0;
      core_do = '0;
      core_nce = 1'b1;
      core_noe = 1'b1;
      core_nwe = 1'b1;
      repeat (3) @(negedge clk_sys);

      chk("rst_busy", clr_busy, 1);
      chk("rst_hold", core_hold, 1);
      chk("rst_err", clr_err, 0);
      chk("rst_lwait", ldr_wait, 0);
      chk("rst_nwe", SRAM_nWE, 1);
      chk("rst_nce", SRAM_nCE, 1);
      chk("rst_noe", SRAM_nOE, 1);
      chk("rst_a", SRAM_A, 0);
      chk("rst_do", SRAM_DO, 0);

      // full-size clear after reset
      clrq();
      reset = 1'b0;
      wait_clear(cnt);
      chk("full_busy", cnt, 1024 + VER * 512);
      chk("full_pulses", pa.size(), 256);
      chk("full_seq", seq_errs(256), 0);
      chk("full_hold", core_hold, 0);
      chk("full_mem0", mem[0], 8'h00);
      chk("full_memff", mem[255], 8'h00);

      // half-size clear
      start_clear(1'b1);
      wait_clear(cnt);
      chk("half_busy", cnt, 512 + VER * 256);
      chk("half_pulses", pa.size(), 128);
      chk("half_seq", seq_errs(128), 0);
      mem_size = 1'b0;

      // core pass-through
      @(negedge clk_sys);
      core_a = 8'h5C;
      core_do = 8'hA5;
      core_nce = 1'b0;
      core_nwe = 1'b0;
      di_ovr_en = 1'b1;
      di_ovr = 8'h3C;
      #1;
      chk("core_a", SRAM_A, 8'h5C);
      chk("core_do", SRAM_DO, 8'hA5);
      chk("core_nwe", SRAM_nWE, 0);
      chk("core_nce", SRAM_nCE, 0);
      chk("core_di", core_di, 8'h3C);
      core_nce = 1'b1;
      core_nwe = 1'b1;
      di_ovr_en = 1'b0;

      // loader write ignored without a session
      @(negedge clk_sys);
      ldr_wr = 1'b1;
      ldr_addr = 8'h44;
      ldr_data = 8'h99;
      @(negedge clk_sys);
      ldr_wr = 1'b0;
      chk("ldr_ign_wait", ldr_wait, 0);
      chk("ldr_ign_nwe", SRAM_nWE, 1);

      // loader write in a session
      @(negedge clk_sys);
      ldr_active = 1'b1;
      #1;
      chk("ldr_hold", core_hold, 1);
      core_nce = 1'b0;
      core_nwe = 1'b0;
      #1;
      chk("ldr_core_blk", SRAM_nWE, 1);
      clrq();
      @(negedge clk_sys);
      ldr_wr = 1'b1;
      ldr_addr = 8'h10;
      ldr_data = 8'h5A;
      @(negedge clk_sys);
      ldr_wr = 1'b0;
      wc = 0;
      for (int i = 0; i < 20 && ldr_wait; i++) begin
         wc++;
         core_nwe = ~core_nwe;
         @(negedge clk_sys);
      end
      chk("ldr_wait_len", wc, 4);
      chk("ldr_pulses", pa.size(), 1);
      chk("ldr_a", pa[0], 8'h10);
      chk("ldr_d", pd[0], 8'h5A);
      chk("ldr_len", pl[0], 2);
      chk("ldr_mem", mem[8'h10], 8'h5A);
      ldr_active = 1'b0;
      core_nce = 1'b1;
      core_nwe = 1'b1;

      // abort a clear mid-way with clr_req
      start_clear(1'b0);
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk_sys);
         if (SRAM_A == 8'h40 && !SRAM_nWE) found = 1'b1;
      end
      chk("abort_found", found, 1);
      clr_req = 1'b1;
      @(negedge clk_sys);
      clr_req = 1'b0;
      #1;
      chk("abort_nwe", SRAM_nWE, 1);
      chk("abort_a", SRAM_A, 0);
      chk("abort_busy", clr_busy, 1);
      clrq();
      wait_clear(cnt);
      chk("abort_cnt", cnt, 1024 + VER * 512);
      chk("abort_seq", seq_errs(256), 0);

      // loader write posted during a clear
      start_clear(1'b0);
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk_sys);
         if (SRAM_A == 8'h80) found = 1'b1;
      end
      chk("post_found", found, 1);
      ldr_active = 1'b1;
      ldr_wr = 1'b1;
      ldr_addr = 8'h22;
      ldr_data = 8'h77;
      @(negedge clk_sys);
      ldr_wr = 1'b0;
      drop = 0;
      found = 1'b0;
      for (int i = 0; i < 4000 && !found; i++) begin
         if (!clr_busy) found = 1'b1;
         else begin
            if (!ldr_wait) drop++;
            @(negedge clk_sys);
         end
      end
      chk("post_end", found, 1);
      chk("post_drop", drop, 0);
      chk("post_idle_wait", ldr_wait, 1);
      chk("post_idle_nce", SRAM_nCE, 1);
      for (int i = 0; i < 20 && ldr_wait; i++) @(negedge clk_sys);
      chk("post_done", ldr_wait, 0);
      chk("post_pulses", pa.size(), 257);
      chk("post_prev", pa[255], 8'hFF);
      chk("post_a", pa[256], 8'h22);
      chk("post_d", pd[256], 8'h77);
      chk("post_mem", mem[8'h22], 8'h77);
      ldr_active = 1'b0;

      // stuck byte during verify
      bad_en = 1'b1;
      start_clear(1'b0);
      wait_clear(cnt);
      chk("bad_busy", cnt, 1024 + VER * 512);
      chk("bad_err", clr_err, VER);
      bad_en = 1'b0;
      start_clear(1'b0);
      chk("err_clr", clr_err, 0);
      wait_clear(cnt);
      chk("good_err", clr_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
